// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM states, instruction field helpers.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned JIDX_W  = 26;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Field views used by decode: op = instr[31:26], funct = instr[5:0].
  function automatic logic [OP_W-1:0] instr_op(input logic [XLEN-1:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [OP_W-1:0] instr_funct(input logic [XLEN-1:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next.sv
// Next-PC selection: jump target beats taken branch beats sequential.
module pc_next
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]   i_pcplus4,
  input  logic [JIDX_W-1:0] i_instr_idx,
  input  logic [XLEN-1:0]   i_signimm,
  input  logic              i_jump,
  input  logic              i_branch_taken,
  output logic [XLEN-1:0]   o_next_pc
);

  logic [XLEN-1:0] w_jump_target;
  logic [XLEN-1:0] w_branch_target;

  assign w_jump_target   = {i_pcplus4[31:28], i_instr_idx, 2'b00};
  assign w_branch_target = i_pcplus4 + XLEN'(i_signimm << 2);

  always_comb begin
    o_next_pc = i_pcplus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_branch_taken) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, req/ack fetch from imem, instruction register,
// next-PC update on retire.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  input  logic        advance,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] signimm,
  output logic [31:0] retired
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_retired;
  logic [XLEN-1:0] w_pcplus4;
  logic [XLEN-1:0] w_next_pc;

  assign w_pcplus4 = r_pc + 32'd4;

  pc_next u_pc_next (
    .i_pcplus4      (w_pcplus4),
    .i_instr_idx    (r_instr[JIDX_W-1:0]),
    .i_signimm      (signimm),
    .i_jump         (jump),
    .i_branch_taken (branch_taken),
    .o_next_pc      (w_next_pc)
  );

  // FSM, PC, IR and retire counter; inputs only act in their owning state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            r_pc      <= w_next_pc;
            r_retired <= r_retired + 32'd1;
            r_state   <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Status decoded straight from the state register so reset clears it at once.
  assign imem_req    = (r_state == FETCH);
  assign instr_valid = (r_state == HOLD);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pcplus4     = w_pcplus4;
  assign instr       = r_instr;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a transaction-level PC model.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        advance;
  logic        jump;
  logic        branch_taken;
  logic [31:0] signimm;

  logic        imem_req,   w_imem_req;
  logic [31:0] imem_addr,  w_imem_addr;
  logic [31:0] instr,      w_instr;
  logic        instr_valid, w_instr_valid;
  logic [31:0] pc,         w_pc;
  logic [31:0] pcplus4,    w_pcplus4;
  logic [31:0] retired,    w_retired;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_pc2, m_instr, m_ret, m_ret2;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pcplus4(pcplus4), .advance(advance),
    .jump(jump), .branch_taken(branch_taken), .signimm(signimm), .retired(retired)
  );

  fetch_stage #(.RESET_PC(WRAP_PC)) dut_w (
    .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w_instr),
    .instr_valid(w_instr_valid), .pc(w_pc), .pcplus4(w_pcplus4), .advance(advance),
    .jump(jump), .branch_taken(branch_taken), .signimm(signimm), .retired(w_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural next-PC rule written with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ir,
                                           input logic j, input logic b, input logic [31:0] imm);
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
    if (b) return seq + imm * 32'd4;
    return seq;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pc2 = WRAP_PC; m_instr = 32'h0; m_ret = 32'h0; m_ret2 = 32'h0;
  endtask

  // Wait for a request, stall the ack for 'delay' cycles, then return 'word'.
  task automatic do_fetch(input int delay, input logic [31:0] word, output int waited);
    waited = 0;
    while (imem_req !== 1'b1 && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    check1("fetch_req", imem_req, 1'b1);
    check("fetch_addr", imem_addr, m_pc);
    check("fetch_addr_w", w_imem_addr, m_pc2);
    check("pcplus4", pcplus4, m_pc + 32'd4);
    for (int d = 0; d < delay; d++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check1("stall_req", imem_req, 1'b1);
      check("stall_addr", imem_addr, m_pc);
      check1("stall_valid", instr_valid, 1'b0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    m_instr = word;
    check1("hold_valid", instr_valid, 1'b1);
    check1("hold_valid_w", w_instr_valid, 1'b1);
    check1("hold_req", imem_req, 1'b0);
    check("hold_instr", instr, m_instr);
    check("hold_pc", pc, m_pc);
  endtask

  // Sit in HOLD for 'holds' cycles with stray acks/controls, then retire once.
  task automatic do_retire(input int holds, input logic j, input logic b, input logic [31:0] imm);
    for (int h = 0; h < holds; h++) begin
      advance = 1'b0;
      jump = 1'($urandom);
      branch_taken = 1'($urandom);
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      @(negedge clk);
      check("idle_hold_instr", instr, m_instr);
      check("idle_hold_pc", pc, m_pc);
      check1("idle_hold_valid", instr_valid, 1'b1);
    end
    imem_ack = 1'b0;
    advance = 1'b1;
    jump = j;
    branch_taken = b;
    signimm = imm;
    @(negedge clk);
    advance = 1'b0;
    jump = 1'b0;
    branch_taken = 1'b0;
    m_pc  = ref_next(m_pc, m_instr, j, b, imm);
    m_pc2 = ref_next(m_pc2, m_instr, j, b, imm);
    m_ret++;
    m_ret2++;
    check1("retire_valid", instr_valid, 1'b0);
    check1("retire_req", imem_req, 1'b1);
    check("retire_count", retired, m_ret);
    check("retire_count_w", w_retired, m_ret2);
  endtask

  initial begin
    int w;
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; advance = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; signimm = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check1("rst_req", imem_req, 1'b0);
    check1("rst_valid", instr_valid, 1'b0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_w", w_pc, WRAP_PC);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired, 32'h0);
    reset = 1'b0;

    // Reset release and zero-wait first fetch.
    do_fetch(0, 32'h2008_0005, w);
    check("first_req_latency", 32'(w), 32'd1);

    // Sequential advance; the wrap instance rolls over to address 0.
    do_retire(0, 1'b0, 1'b0, 32'h0);
    check("seq_addr", imem_addr, 32'h0000_0004);
    check("wrap_addr", w_imem_addr, 32'h0000_0000);
    do_fetch(3, 32'h0800_0004, w);
    do_retire(1, 1'b1, 1'b0, 32'h0);
    check("jump_to_10", imem_addr, 32'h0000_0010);

    // Backward and forward branches from 0x10.
    do_fetch(0, 32'h1000_FFFE, w);
    do_retire(2, 1'b0, 1'b1, 32'hFFFF_FFFE);
    check("branch_back", imem_addr, 32'h0000_000C);
    do_fetch(1, 32'h0800_0004, w);
    do_retire(0, 1'b1, 1'b0, 32'h0);
    do_fetch(0, 32'h1000_0003, w);
    do_retire(0, 1'b0, 1'b1, 32'h0000_0003);
    check("branch_fwd", imem_addr, 32'h0000_0020);

    // Reach 0x40000000, then jump and branch together: jump wins.
    do_fetch(2, 32'h1000_0000, w);
    do_retire(0, 1'b0, 1'b1, 32'h0FFF_FFF7);
    check("branch_far", imem_addr, 32'h4000_0000);
    do_fetch(0, 32'h0800_0011, w);
    do_retire(1, 1'b1, 1'b1, 32'h0000_0005);
    check("jump_priority", imem_addr, 32'h4000_0044);

    // Retire counter wrap.
    do_fetch(0, $urandom, w);
    force dut.r_retired = 32'hFFFF_FFFF;
    #1;
    release dut.r_retired;
    #1;
    m_ret = 32'hFFFF_FFFF;
    do_retire(0, 1'b0, 1'b0, 32'h0);
    check("retired_wrap", retired, 32'h0);

    // Advance held high: one retire per HOLD visit, 2-cycle throughput.
    advance = 1'b1;
    imem_ack = 1'b0;
    @(negedge clk);
    check("adv_hi_fetch_count", retired, m_ret);
    check1("adv_hi_fetch_req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0022; m_instr = 32'h0000_0020;
    check1("adv_hi_valid", instr_valid, 1'b1);
    check("adv_hi_instr", instr, m_instr);
    @(negedge clk);
    m_pc = ref_next(m_pc, m_instr, 1'b0, 1'b0, 32'h0);
    m_pc2 = ref_next(m_pc2, m_instr, 1'b0, 1'b0, 32'h0);
    m_ret++; m_ret2++;
    check("adv_hi_retire1", retired, m_ret);
    check1("adv_hi_req", imem_req, 1'b1);
    @(negedge clk);
    m_instr = 32'h0000_0022;
    check("adv_hi_no_double", retired, m_ret);
    check("adv_hi_instr2", instr, m_instr);
    @(negedge clk);
    advance = 1'b0; imem_ack = 1'b0;
    m_pc = ref_next(m_pc, m_instr, 1'b0, 1'b0, 32'h0);
    m_pc2 = ref_next(m_pc2, m_instr, 1'b0, 1'b0, 32'h0);
    m_ret++; m_ret2++;
    check("adv_hi_retire2", retired, m_ret);
    check("adv_hi_addr", imem_addr, m_pc);

    // Reset mid-HOLD drops instr_valid asynchronously.
    do_fetch(1, $urandom, w);
    reset = 1'b1;
    #1;
    check1("rst_hold_valid", instr_valid, 1'b0);
    check("rst_hold_retired", retired, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_fetch(0, $urandom, w);
    do_retire(0, 1'b0, 1'b0, 32'h0);

    // Reset mid-FETCH, late ack during IDLE is ignored.
    reset = 1'b1;
    #1;
    check1("rst_fetch_req", imem_req, 1'b0);
    check("rst_fetch_addr", imem_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check1("late_ack_valid", instr_valid, 1'b0);
    check1("late_ack_req", imem_req, 1'b1);
    check("late_ack_instr", instr, 32'h0);
    do_fetch(0, 32'h2008_0005, w);

    // Randomized traffic against the reference model.
    do_retire(0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 40; n++) begin
      do_fetch(int'($urandom_range(0, 3)), $urandom, w);
      do_retire(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage. It sits directly upstream of the main decoder and ALU decoder.
- Holds the PC and fetches the instruction word from instruction memory over a req/ack handshake.
- Presents the instruction in an instruction register, from which the decoder takes op = instr[31:26] and funct = instr[5:0].
- Computes the next PC from the decoder's jump and branch results when the downstream stage retires the instruction.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address; equals pc
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word from memory
- instr  output  32  instruction register; feeds op/funct/fields to decode
- instr_valid  output  1  instr holds a fetched, unretired instruction
- pc  output  32  address of the current instruction
- pcplus4  output  32  pc + 4; combinational
- advance  input  1  downstream retires the current instruction this cycle
- jump  input  1  decoder jump control for the current instruction
- branch_taken  input  1  branch AND zero, from the datapath
- signimm  input  32  sign-extended immediate of the current instruction
- retired  output  32  count of retired instructions

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high. All state is in a single always_ff on posedge clk or posedge reset.
- Reset values:
  - state = IDLE
  - pc = RESET_PC
  - instr = 0
  - instr_valid = 0
  - imem_req = 0
  - retired = 0
- FSM states: IDLE, FETCH, HOLD.
  - IDLE: imem_req = 0. Goes to FETCH on the next edge, unconditionally.
  - FETCH: imem_req = 1 and imem_addr = pc, both held stable until ack. On imem_ack: instr <= imem_rdata and the state goes to HOLD. Without ack, stay in FETCH.
  - HOLD: instr_valid = 1. On advance: pc <= next_pc, retired <= retired + 1, and the state goes to FETCH. Without advance, stay in HOLD with instr and pc unchanged.
- Decoded outputs: imem_req = (state == FETCH) and instr_valid = (state == HOLD), both decoded from the registered state.
- Ack timing: ack may arrive in the same cycle req rises.
  - Minimum latency is ack to instr_valid = 1 cycle.
  - Minimum throughput is one instruction per 2 cycles.
- next_pc selection, in priority order:
  1. jump: {pcplus4[31:28], instr[25:0], 2'b00}
  2. branch_taken: pcplus4 + {signimm[29:0], 2'b00}
  3. otherwise: pcplus4
- Arithmetic: all adds are 32-bit modulo and wrap silently. pc[1:0] is always 00.
- Boundary conditions:
  - jump and branch_taken both high: jump wins.
  - advance, jump and branch_taken are ignored outside HOLD.
  - imem_ack is ignored outside FETCH, including a late ack after reset.
  - pc = 32'hFFFF_FFFC with a sequential advance: wraps to 32'h0000_0000.
  - retired wraps from 32'hFFFF_FFFF to 0.
  - Reset asserted mid-FETCH or mid-HOLD: imem_req and instr_valid drop immediately (asynchronously), and the outstanding access is abandoned.
  - advance held high continuously: retires exactly one instruction per HOLD visit, never two.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ORI
  - the fetch_state_t enum {IDLE, FETCH, HOLD}
  - the default RESET_PC
- One combinational sub-module, pc_next. Inputs: pcplus4, instr[25:0], signimm, jump, branch_taken. Output: next_pc. It is reused later by the branch-prediction work.
- The FSM, PC, IR and counter stay in fetch_stage.

Test Plan:
1. Reset sequence: reset high, then low; memory acks in the first request cycle with 32'h2008_0005 → imem_req rises 1 cycle after reset release, imem_addr = 0. On the next cycle instr = 32'h2008_0005, instr_valid = 1, pc = 0.
2. Sequential fetch: advance with jump = 0 and branch_taken = 0 → next request address = 32'h0000_0004, retired = 1. With a 3-cycle ack delay, imem_addr stays 32'h4 and instr_valid stays 0 throughout.
3. Branch: pc = 32'h10, signimm = 32'hFFFF_FFFE, branch_taken = 1, advance → next fetch address 32'h0C. With signimm = 32'h3 instead → 32'h20.
4. Jump priority: pc = 32'h4000_0000, instr = 32'h0800_0011, jump = 1 and branch_taken = 1 → next fetch address 32'h4000_0044.
5. Wrap: RESET_PC = 32'hFFFF_FFFC, sequential advance → fetch address 32'h0000_0000. Separately, force retired = 32'hFFFF_FFFF, then advance → retired = 0.
6. Reset mid-fetch: assert reset while in FETCH, then ack one cycle after release → imem_req = 0 immediately on reset. The late ack is ignored, and the first valid instr comes from a fresh fetch of RESET_PC.
